// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with a 2-bit IR, a bypass register and
// strobes for the boundary-scan and internal-scan register groups.
module jtag_tap_ctrl (
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       TDO_BSR,
    input  logic       TDO_ISR,
    output logic       TDO,
    output logic       tdo_en,
    output logic [1:0] inst,
    output logic       clockdr_bs,
    output logic       shiftdr_bs,
    output logic       updatedr_bs,
    output logic       clockdr_is,
    output logic       shiftdr_is,
    output logic       updatedr_is,
    output logic [3:0] tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] ir;
    logic       bypass;
    logic       shifting;
    logic       tdo_src;
    logic       sel_bs;
    logic       sel_is;

    always_ff @(posedge TCLK) begin
        if (TRST) state <= TLR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            TLR:    state_nx = TMS ? TLR    : RTI;
            RTI:    state_nx = TMS ? SEL_DR : RTI;
            SEL_DR: state_nx = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nx = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nx = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nx = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_nx = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_nx = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nx = TMS ? SEL_DR : RTI;
            SEL_IR: state_nx = TMS ? TLR    : CAP_IR;
            CAP_IR: state_nx = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nx = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nx = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_nx = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_nx = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nx = TMS ? SEL_DR : RTI;
        endcase
    end

    assign shifting = (state == SH_DR) || (state == SH_IR);

    always_comb begin
        tdo_src = 1'b0;
        if (state == SH_IR) tdo_src = ir[0];
        else begin
            unique case (inst)
                2'b00:   tdo_src = TDO_BSR;
                2'b01:   tdo_src = bypass;
                default: tdo_src = TDO_ISR;
            endcase
        end
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            ir     <= 2'b01;
            inst   <= 2'b01;
            bypass <= 1'b0;
            TDO    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            if (state == CAP_IR)     ir <= 2'b01;
            else if (state == SH_IR) ir <= {TDI, ir[1]};
            // inst already reads BYPASS on the edge that lands in TLR
            if (state_nx == TLR)      inst <= 2'b01;
            else if (state == UPD_IR) inst <= ir;
            if (inst == 2'b01) begin
                if (state == CAP_DR)     bypass <= 1'b0;
                else if (state == SH_DR) bypass <= TDI;
            end
            TDO    <= shifting ? tdo_src : 1'b0;
            tdo_en <= shifting;
        end
    end

    assign sel_bs = (inst == 2'b00);
    assign sel_is = inst[1];

    assign clockdr_bs  = sel_bs && (state == CAP_DR || state == SH_DR);
    assign shiftdr_bs  = sel_bs && (state == SH_DR);
    assign updatedr_bs = sel_bs && (state == UPD_DR);
    assign clockdr_is  = sel_is && (state == CAP_DR || state == SH_DR);
    assign shiftdr_is  = sel_is && (state == SH_DR);
    assign updatedr_is = sel_is && (state == UPD_DR);
    assign tap_state   = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IR load, EXTEST, BYPASS,
// pause/resume, TMS escape and TRST abort.
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b0;
    logic       TDI = 1'b0;
    logic       TDO_BSR = 1'b0;
    logic       TDO_ISR = 1'b0;
    logic       TDO;
    logic       tdo_en;
    logic [1:0] inst;
    logic       clockdr_bs, shiftdr_bs, updatedr_bs;
    logic       clockdr_is, shiftdr_is, updatedr_is;
    logic [3:0] tap_state;
    logic [5:0] strb;

    int errs = 0;
    int checks = 0;

    jtag_tap_ctrl dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR),
        .TDO(TDO), .tdo_en(tdo_en), .inst(inst),
        .clockdr_bs(clockdr_bs), .shiftdr_bs(shiftdr_bs),
        .updatedr_bs(updatedr_bs),
        .clockdr_is(clockdr_is), .shiftdr_is(shiftdr_is),
        .updatedr_is(updatedr_is),
        .tap_state(tap_state)
    );

    always #5 TCLK = ~TCLK;

    // {clk_bs, sh_bs, upd_bs, clk_is, sh_is, upd_is}
    assign strb = {clockdr_bs, shiftdr_bs, updatedr_bs,
                   clockdr_is, shiftdr_is, updatedr_is};

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    // From RTI, load IR with v and return to RTI
    task automatic ir_load(input logic [1:0] v);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, v[0]); step(1, v[1]); step(1, 0); step(0, 0);
    endtask

    initial begin
        TRST = 1'b1;
        step(0, 0);
        chk("rst_state", 8'(tap_state), 8'hF);
        chk("rst_inst", 8'(inst), 8'h1);
        chk("rst_strb", 8'(strb), 8'h00);
        chk("rst_tdo", {6'd0, TDO, tdo_en}, 8'h0);
        TRST = 1'b0;
        step(1, 0);
        chk("tlr_hold", 8'(tap_state), 8'hF);

        // IR load of EXTEST
        step(0, 0); chk("rti", 8'(tap_state), 8'hC);
        step(1, 0); chk("seldr", 8'(tap_state), 8'h7);
        step(1, 0); chk("selir", 8'(tap_state), 8'h4);
        step(0, 0); chk("capir", 8'(tap_state), 8'hE);
        step(0, 0); chk("shir", 8'(tap_state), 8'hA);
        step(0, 0); chk("ir_tdo0", {6'd0, TDO, tdo_en}, 8'h3);
        step(1, 0); chk("ex1ir", 8'(tap_state), 8'h9);
        chk("ir_tdo1", {6'd0, TDO, tdo_en}, 8'h1);
        step(1, 0); chk("updir", 8'(tap_state), 8'hD);
        chk("updir_en", 8'(tdo_en), 8'h0);
        step(0, 0); chk("inst_ext", 8'(inst), 8'h0);

        // EXTEST DR scan
        step(1, 0);
        step(0, 0); chk("ext_cap", 8'(strb), 8'h20);
        TDO_BSR = 1'b1;
        step(0, 0); chk("ext_sh", 8'(strb), 8'h30);
        step(0, 0); chk("ext_tdo", 8'(TDO), 8'h1);
        TDO_BSR = 1'b0;
        step(1, 0); chk("ext_ex1", 8'(strb), 8'h00);
        chk("ext_tdo0", 8'(TDO), 8'h0);
        step(1, 0); chk("ext_upd", 8'(strb), 8'h08);
        step(0, 0); chk("ext_upd1", 8'(strb), 8'h00);
        chk("ext_inst", 8'(inst), 8'h0);

        // BYPASS
        ir_load(2'b01);
        chk("inst_byp", 8'(inst), 8'h1);
        step(1, 0);
        step(0, 0); chk("byp_cap", 8'(strb), 8'h00);
        step(0, 0); chk("byp_sh", 8'(tap_state), 8'h2);
        step(0, 1); chk("byp_b0", {6'd0, TDO, tdo_en}, 8'h1);
        step(0, 0); chk("byp_b1", {6'd0, TDO, tdo_en}, 8'h3);
        step(0, 1); chk("byp_b2", {6'd0, TDO, tdo_en}, 8'h1);
        step(0, 1); chk("byp_b3", {6'd0, TDO, tdo_en}, 8'h3);
        chk("byp_strb", 8'(strb), 8'h00);
        step(1, 0); chk("byp_b4", {6'd0, TDO, tdo_en}, 8'h3);
        step(1, 0); chk("byp_upd", 8'(strb), 8'h00);
        step(0, 0);

        // INTSCAN pause/resume
        ir_load(2'b10);
        chk("inst_int", 8'(inst), 8'h2);
        step(1, 0);
        step(0, 0); chk("int_cap", 8'(strb), 8'h04);
        step(0, 0); chk("int_sh", 8'(strb), 8'h06);
        step(1, 0); chk("int_ex1", 8'(strb), 8'h00);
        step(0, 0); chk("pau0", 8'(tap_state), 8'h3);
        step(0, 0); step(0, 0);
        chk("pau2", {tap_state, 4'(strb)}, 8'h30);
        step(1, 0); chk("ex2dr", 8'(tap_state), 8'h0);
        step(0, 0); chk("resume", 8'(tap_state), 8'h2);
        chk("resume_strb", 8'(strb), 8'h06);
        TDO_ISR = 1'b1;
        step(0, 0); chk("isr_tdo", 8'(TDO), 8'h1);
        TDO_ISR = 1'b0;
        step(1, 0); step(1, 0);
        chk("int_upd", 8'(strb), 8'h01);
        step(0, 0);

        // BIST then TMS escape
        ir_load(2'b11);
        chk("inst_bist", 8'(inst), 8'h3);
        step(1, 0); step(0, 0); step(0, 0);
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        chk("esc4", {tap_state, 2'b00, inst}, 8'h43);
        step(1, 0);
        chk("esc5", {tap_state, 2'b00, inst}, 8'hF1);

        // TRST abort mid-shift
        step(0, 0);
        ir_load(2'b00);
        step(1, 0); step(0, 0); step(0, 0);
        chk("abt_sh", 8'(strb), 8'h30);
        TRST = 1'b1;
        step(1, 0);
        chk("abt_state", {tap_state, 2'b00, inst}, 8'hF1);
        chk("abt_strb", 8'(strb), 8'h00);
        chk("abt_tdo", {6'd0, TDO, tdo_en}, 8'h0);
        TRST = 1'b0;
        step(1, 0);
        chk("abt_post", {tap_state, 4'(strb)}, 8'hF0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 The block SHALL have port TCLK, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-002 The block SHALL have port TRST, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port TMS, input, 1 bit: TAP mode select, sampled on the rising edge of TCLK.
REQ-004 The block SHALL have port TDI, input, 1 bit: serial test data in, routed to the IR shift register and bypass register.
REQ-005 The block SHALL have port TDO_BSR, input, 1 bit: serial out of the boundary-scan register chain.
REQ-006 The block SHALL have port TDO_ISR, input, 1 bit: serial out of the internal scan chain.
REQ-007 The block SHALL have port TDO, output, 1 bit: registered serial test data out.
REQ-008 The block SHALL have port tdo_en, output, 1 bit: TDO valid, high only while TDO carries shifted data.
REQ-009 The block SHALL have port inst, output, 2 bits: active instruction; 00 EXTEST (BSR), 01 BYPASS, 10 INTSCAN (ISR), 11 BIST (ISR).
REQ-010 The block SHALL have ports clockdr_bs, shiftdr_bs and updatedr_bs, outputs, 1 bit each: boundary-scan register strobes.
REQ-011 The block SHALL have ports clockdr_is, shiftdr_is and updatedr_is, outputs, 1 bit each: internal-scan register strobes.
REQ-012 The block SHALL have port tap_state, output, 4 bits: current TAP state, for debug and verification.

Function
REQ-013 The FSM SHALL implement the 16 IEEE 1149.1 states with these tap_state encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-014 On each edge the FSM SHALL take the TMS=0 / TMS=1 transition shown below:
- TLR -> RTI / TLR
- RTI -> RTI / SelDR
- SelDR -> CapDR / SelIR
- SelIR -> CapIR / TLR
- CapX -> ShX / Ex1X
- ShX -> ShX / Ex1X
- Ex1X -> PauX / UpdX
- PauX -> PauX / Ex2X
- Ex2X -> ShX / UpdX
- UpdX -> RTI / SelDR
REQ-015 Five consecutive TMS=1 samples SHALL reach TLR from any state.
REQ-016 The 2-bit IR shift register SHALL:
- load 2'b01 in CapIR;
- in ShIR, shift right with TDI entering the MSB and the LSB driving the TDO source;
- hold in all other states.
REQ-017 inst SHALL load from the IR shift register on the edge leaving UpdIR, and SHALL be forced to 01 whenever the state is TLR.
REQ-018 The DR group SHALL be selected by inst: 00 -> bs strobes; 10 or 11 -> is strobes; 01 -> internal 1-bit bypass register, with no external strobes.
REQ-019 The strobes SHALL be Moore outputs decoded from the registered state, gated by the selected group:
- clockdr_x = 1 in CapDR or ShDR;
- shiftdr_x = 1 in ShDR only;
- updatedr_x = 1 in UpdDR only.
REQ-020 updatedr_x SHALL be high for exactly one cycle per UpdDR visit; the unselected group SHALL stay 0 throughout.
REQ-021 The bypass register SHALL load 0 in CapDR and load TDI in ShDR when inst=01; otherwise it holds.
REQ-022 TDO SHALL be registered:
- on an edge where the state is ShDR or ShIR, TDO <= the source, where the source is the IR LSB (ShIR), TDO_BSR (inst 00), bypass (inst 01), or TDO_ISR (inst 10/11);
- otherwise TDO <= 0.
REQ-023 tdo_en SHALL register (state==ShDR or state==ShIR) on the same edge as TDO.
REQ-024 A Pause state SHALL hold all shift registers with all strobes at 0; re-entering ShX via Ex2X SHALL resume shifting without a new capture.
REQ-025 inst SHALL NOT change during any DR path state; it changes only on UpdIR exit or in TLR.

Reset
REQ-026 When TRST=1 at a rising edge, the next state SHALL be TLR, with inst=01, IR shift register=01, bypass=0, TDO=0 and tdo_en=0.
REQ-027 While in reset all six strobes SHALL be 0, and TRST SHALL take priority over TMS.
REQ-028 A TRST arriving mid-shift SHALL abort the shift with no update strobe issued.
REQ-029 After TRST deasserts, the FSM SHALL remain in TLR while TMS=1.

Verification
REQ-030 Reset: TRST=1 for 1 cycle -> tap_state=F, inst=01, all strobes 0, TDO=0, tdo_en=0.
REQ-031 IR load:
- stimulus: from TLR, TMS 0,1,1,0,0 reaches ShIR (A); then TDI 0,0 with TMS 0,1, then TMS 1;
- tap_state sequence 9, then D;
- inst=00 on the cycle after D;
- TDO emits 1 then 0, with tdo_en high for both bits.
REQ-032 EXTEST DR scan:
- stimulus: inst=00, from RTI TMS 1,0,0,0;
- clockdr_bs=1 in CapDR, then clockdr_bs=shiftdr_bs=1 in ShDR;
- all _is strobes stay 0;
- TDO equals TDO_BSR one cycle later;
- exit through Ex1DR/UpdDR gives updatedr_bs=1 for exactly 1 cycle.
REQ-033 BYPASS:
- stimulus: inst=01, shift TDI=1,0,1,1 in ShDR;
- TDO stream = 0 (captured),1,0,1,1;
- no bs or is strobe ever asserts.
REQ-034 Pause/resume with inst=10:
- stimulus: ShDR -> Ex1DR -> PauDR for 3 cycles -> Ex2DR -> ShDR;
- shiftdr_is is 0 during pause and resumes;
- no clockdr_is pulse in the CapDR sense occurs on resume.
REQ-035 Escape and abort:
- stimulus: five TMS=1 from ShDR with inst=11 -> tap_state=F and inst=01 on the fifth edge;
- stimulus: TRST=1 during ShDR -> TLR on the next edge, with no updatedr pulse.
